// File: rtl/fault_test_sequencer.sv
// fault_test_sequencer: applies stored test vectors to a golden/faulty CUT pair and tallies output mismatches (rev 1.0).
// Defining FTS_SIGNATURE_EN adds a 16-bit MISR signature output over the compared CUT outputs.
`default_nettype none

module fault_test_sequencer #(
  parameter int IN_W       = 3,
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [IN_W-1:0] load_data,
  input  logic [AW:0]     num_vec,
  input  logic            start,
  input  logic            abort,
  output logic [IN_W-1:0] cut_in,
  input  logic            true_out,
  input  logic            fault_out,
  output logic            busy,
  output logic            done,
  output logic            detected,
  output logic [AW:0]     mismatch_cnt,
  output logic [AW-1:0]   first_fail_idx,
  output logic            fail_valid
`ifdef FTS_SIGNATURE_EN
  ,
  output logic [15:0]     signature
`endif
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     n_q, n_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic [IN_W-1:0] cut_q, cut_d;
  logic            done_q, done_d;
  logic            det_q, det_d;
  logic [AW:0]     mcnt_q, mcnt_d;
  logic [AW-1:0]   ffi_q, ffi_d;
  logic            fv_q, fv_d;
  logic            mismatch;
`ifdef FTS_SIGNATURE_EN
  logic [15:0]     sig_q, sig_d;
`endif

  // Vector memory is not reset and is frozen while a run is in progress.
  logic [IN_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en && !busy) mem[load_addr] <= load_data;
  end

  assign mismatch = true_out ^ fault_out;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    cut_d   = cut_q;
    done_d  = done_q;
    det_d   = det_q;
    mcnt_d  = mcnt_q;
    ffi_d   = ffi_q;
    fv_d    = fv_q;
`ifdef FTS_SIGNATURE_EN
    sig_d   = sig_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          n_d    = (num_vec > N_MAX) ? N_MAX : num_vec;
          idx_d  = '0;
          done_d = 1'b0;
          det_d  = 1'b0;
          mcnt_d = '0;
          ffi_d  = '0;
          fv_d   = 1'b0;
`ifdef FTS_SIGNATURE_EN
          sig_d  = 16'hFFFF;
`endif
          if (n_d == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = APPLY;
            cut_d   = mem[0];
          end
        end
      end
      APPLY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          scnt_d  = CW'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (abort)             state_d = IDLE;
        else if (scnt_q == '0) state_d = COMPARE;
        else                   scnt_d  = scnt_q - 1'b1;
      end
      COMPARE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (mismatch) begin
            mcnt_d = mcnt_q + 1'b1;
            det_d  = 1'b1;
            if (!fv_q) begin
              ffi_d = idx_q;
              fv_d  = 1'b1;
            end
          end
`ifdef FTS_SIGNATURE_EN
          sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {14'b0, fault_out, true_out};
`endif
          if ({1'b0, idx_q} == n_q - 1'b1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            cut_d   = mem[idx_q + 1'b1];
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      scnt_q  <= '0;
      cut_q   <= '0;
      done_q  <= 1'b0;
      det_q   <= 1'b0;
      mcnt_q  <= '0;
      ffi_q   <= '0;
      fv_q    <= 1'b0;
`ifdef FTS_SIGNATURE_EN
      sig_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      cut_q   <= cut_d;
      done_q  <= done_d;
      det_q   <= det_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      fv_q    <= fv_d;
`ifdef FTS_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign busy           = (state_q == APPLY) || (state_q == SETTLE) || (state_q == COMPARE);
  assign cut_in         = cut_q;
  assign done           = done_q;
  assign detected       = det_q;
  assign mismatch_cnt   = mcnt_q;
  assign first_fail_idx = ffi_q;
  assign fail_valid     = fv_q;
`ifdef FTS_SIGNATURE_EN
  assign signature      = sig_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fault_test_sequencer.sv
// tb_fault_test_sequencer: directed vector table plus hand sequences for abort, reset and busy-time inputs.
`default_nettype none

module tb_fault_test_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [2:0] load_addr;
  logic [2:0] load_data;
  logic [3:0] num_vec;
  logic       start;
  logic       abort;
  logic [2:0] cut_in;
  logic       true_out;
  logic       fault_out;
  logic       busy;
  logic       done;
  logic       detected;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail_idx;
  logic       fail_valid;

  int checks = 0;
  int errors = 0;

  fault_test_sequencer #(.IN_W(3), .DEPTH(8), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start), .abort(abort),
    .cut_in(cut_in), .true_out(true_out), .fault_out(fault_out), .busy(busy),
    .done(done), .detected(detected), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .fail_valid(fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CUT pair: full-adder carry, {Cin,A,B}; faulty copy has the A^B gate stuck at 0.
  assign true_out  = (cut_in[1] & cut_in[0]) | (cut_in[2] & (cut_in[1] ^ cut_in[0]));
  assign fault_out = cut_in[1] & cut_in[0];

  typedef struct {
    int          nload;
    logic [23:0] vecs;
    logic [3:0]  nv;
    int          exp_edges;
    logic [3:0]  exp_cnt;
    logic        exp_det;
    logic        exp_fv;
    logic [2:0]  exp_ffi;
    logic [2:0]  exp_cut;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [2:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Returns the number of edges up to and including the one where done is seen, counting the start edge as 1.
  task automatic run(input logic [3:0] nv, output int edges, output logic busy_seen);
    @(negedge clk);
    num_vec = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_seen = busy;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic edge_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int   edges;
    logic bs;
    logic [2:0] exp_seq [9];

    tbl[0] = '{2, {18'b0, 3'b110, 3'b101}, 4'd2, 7, 4'd2, 1'b1, 1'b1, 3'd0, 3'b110, 1'b1};
    tbl[1] = '{1, {21'b0, 3'b011}, 4'd1, 4, 4'd0, 1'b0, 1'b0, 3'd0, 3'b011, 1'b1};
    tbl[2] = '{3, {15'b0, 3'b101, 3'b110, 3'b011}, 4'd3, 10, 4'd2, 1'b1, 1'b1, 3'd1, 3'b101, 1'b1};
    tbl[3] = '{0, 24'b0, 4'd0, 1, 4'd0, 1'b0, 1'b0, 3'd0, 3'b101, 1'b0};
    tbl[4] = '{8, {3'b101, 3'b010, 3'b001, 3'b110, 3'b111, 3'b101, 3'b000, 3'b011},
               4'd13, 25, 4'd3, 1'b1, 1'b1, 3'd2, 3'b101, 1'b1};

    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = '0; start = 1'b0; abort = 1'b0;
    edge_wait(3);
    check("reset_outputs", {busy, done, detected, fail_valid, mismatch_cnt, first_fail_idx, cut_in}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      for (int a = 0; a < tbl[t].nload; a++) begin
        logic [23:0] vv;
        vv = tbl[t].vecs >> (3 * a);
        load(3'(a), vv[2:0]);
      end
      run(tbl[t].nv, edges, bs);
      check($sformatf("t%0d_edges", t), edges, tbl[t].exp_edges);
      check($sformatf("t%0d_done", t), done, 1'b1);
      check($sformatf("t%0d_cnt", t), mismatch_cnt, tbl[t].exp_cnt);
      check($sformatf("t%0d_det", t), detected, tbl[t].exp_det);
      check($sformatf("t%0d_fv", t), fail_valid, tbl[t].exp_fv);
      check($sformatf("t%0d_ffi", t), first_fail_idx, tbl[t].exp_ffi);
      check($sformatf("t%0d_cut", t), cut_in, tbl[t].exp_cut);
      check($sformatf("t%0d_busy_seen", t), bs, tbl[t].exp_busy);
    end

    edge_wait(2);
    check("done_sticky", {done, busy}, 2'b10);

    // cut_in sequence for three vectors, each held three cycles
    load(3'd0, 3'b011); load(3'd1, 3'b110); load(3'd2, 3'b101);
    exp_seq = '{3'b011, 3'b011, 3'b011, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101};
    @(negedge clk); num_vec = 4'd3; start = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("seq_cut_e%0d", e + 1), cut_in, exp_seq[e]);
    end
    edge_wait(1);
    check("seq_done", done, 1'b1);

    // abort during SETTLE of vector 1
    load(3'd0, 3'b101); load(3'd1, 3'b110);
    @(negedge clk); num_vec = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edge_wait(4);
    check("abort_pre_busy", busy, 1'b1);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_state", {busy, done}, 2'b00);
    check("abort_cnt", mismatch_cnt, 4'd1);
    check("abort_flags", {detected, fail_valid, first_fail_idx}, {1'b1, 1'b1, 3'd0});
    check("abort_cut", cut_in, 3'b110);
    edge_wait(2);
    check("abort_idle", {busy, done}, 2'b00);
    run(4'd2, edges, bs);
    check("rerun_edges", edges, 7);
    check("rerun_cnt", mismatch_cnt, 4'd2);

    // abort in the COMPARE cycle discards that sample
    @(negedge clk); num_vec = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edge_wait(2);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_cmp", {busy, done, detected, fail_valid, mismatch_cnt}, 8'h0);

    // start together with abort while idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    edge_wait(1);
    check("start_abort", {busy, done}, 2'b00);

    // load_en and start while busy have no effect
    @(negedge clk); num_vec = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    load_en = 1'b1; load_addr = 3'd1; load_data = 3'b011; start = 1'b1; num_vec = 4'd1;
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 4) begin load_en = 1'b0; start = 1'b0; end
    end
    load_en = 1'b0; start = 1'b0;
    check("busy_ignore_edges", edges, 7);
    check("busy_ignore_cnt", mismatch_cnt, 4'd2);
    run(4'd2, edges, bs);
    check("mem_frozen_cnt", mismatch_cnt, 4'd2);
    check("mem_frozen_cut", cut_in, 3'b110);

    // asynchronous reset in COMPARE
    @(negedge clk); num_vec = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edge_wait(2);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, detected, fail_valid, mismatch_cnt, first_fail_idx, cut_in}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    edge_wait(3);
    check("post_reset_idle", {busy, done, mismatch_cnt}, 6'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
